// File: rtl/pred_update_queue.sv
// rtl/pred_update_queue.sv - dual-commit branch predictor update FIFO
// Buffers up to two retired branches per cycle and delivers one update per cycle.
module pred_update_queue #(
  parameter int PRED_TABLE_BIT = 6,
  parameter int DEPTH          = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      c0_valid,
  input  logic                      c1_valid,
  input  logic                      c0_res,
  input  logic                      c1_res,
  input  logic                      c0_correct,
  input  logic                      c1_correct,
  input  logic [PRED_TABLE_BIT-1:0] c0_g_ind,
  input  logic [PRED_TABLE_BIT-1:0] c1_g_ind,
  input  logic [PRED_TABLE_BIT-1:0] c0_l_ind,
  input  logic [PRED_TABLE_BIT-1:0] c1_l_ind,
  output logic                      q_full,
  output logic                      br_req,
  output logic                      br_correct,
  output logic [31:0]               br_res,
  output logic [PRED_TABLE_BIT-1:0] br_g_ind,
  output logic [PRED_TABLE_BIT-1:0] br_l_ind,
  output logic [31:0]               stat_total,
  output logic [31:0]               stat_miss,
  output logic                      ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic                      res;
    logic                      correct;
    logic [PRED_TABLE_BIT-1:0] g_ind;
    logic [PRED_TABLE_BIT-1:0] l_ind;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head_e;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] tail_c1;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic [CW-1:0] count_nxt;
  logic          deq;
  logic          acc0;
  logic          acc1;
  logic          drop;

  // Free slots count the head leaving this edge, so a full queue still takes one commit.
  always_comb begin
    deq       = rdy_in && (count != '0);
    free      = DEPTH_C - count + CW'(deq);
    acc0      = rdy_in && c0_valid && (free != '0);
    acc1      = rdy_in && c1_valid && (free > CW'(acc0));
    drop      = rdy_in && ((c0_valid && !acc0) || (c1_valid && !acc1));
    tail_c1   = tail + PW'(acc0);
    count_nxt = count + CW'(acc0) + CW'(acc1) - CW'(deq);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      stat_total <= '0;
      stat_miss  <= '0;
    end else if (rdy_in) begin
      count <= count_nxt;
      tail  <= tail + PW'(acc0) + PW'(acc1);
      if (deq) begin
        head <= head + PW'(1);
        if (stat_total != '1) stat_total <= stat_total + 32'd1;
        if (!head_e.correct && stat_miss != '1) stat_miss <= stat_miss + 32'd1;
      end
      if (drop) ovf <= 1'b1;
    end
  end

  // Entry storage carries no reset; outputs are masked whenever the queue is empty.
  always_ff @(posedge clk_in) begin
    if (acc0) mem[tail]    <= {c0_res, c0_correct, c0_g_ind, c0_l_ind};
    if (acc1) mem[tail_c1] <= {c1_res, c1_correct, c1_g_ind, c1_l_ind};
  end

  assign head_e = mem[head];
  assign q_full = (DEPTH_C - count) < CW'(2);

  always_comb begin
    br_req     = (count != '0);
    br_correct = 1'b0;
    br_res     = '0;
    br_g_ind   = '0;
    br_l_ind   = '0;
    if (br_req) begin
      br_correct = head_e.correct;
      br_res     = {31'b0, head_e.res};
      br_g_ind   = head_e.g_ind;
      br_l_ind   = head_e.l_ind;
    end
  end

endmodule

// File: doc/pred_update_queue.md
PRED_UPDATE_QUEUE -- requirements
Module: pred_update_queue

Interface
REQ-001 SHALL have parameter PRED_TABLE_BIT, default 6, width of predictor global/local table indices.
REQ-002 SHALL have parameter DEPTH, default 8, queue entries; power of two, >= 4.
REQ-003 SHALL have port clk_in  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-low; state clears immediately while low.
REQ-005 SHALL have port rdy_in  input  1  global ready; low freezes all state.
REQ-006 SHALL have ports c0_valid, c1_valid  input  1 each  commit port 0/1 retiring a branch; port 0 is older.
REQ-007 SHALL have ports c0_res, c1_res  input  1 each  actual outcome, 1 = taken.
REQ-008 SHALL have ports c0_correct, c1_correct  input  1 each  prediction matched outcome.
REQ-009 SHALL have ports c0_g_ind, c1_g_ind, c0_l_ind, c1_l_ind  input  PRED_TABLE_BIT each  indices captured at prediction time.
REQ-010 SHALL have port q_full  output  1  high when fewer than 2 free entries; commit stage SHALL NOT retire branches while high.
REQ-011 SHALL have port br_req  output  1  update valid toward predictor.
REQ-012 SHALL have ports br_correct  output  1; br_res  output  32 (zero-extended outcome); br_g_ind, br_l_ind  output  PRED_TABLE_BIT.
REQ-013 SHALL have ports stat_total, stat_miss  output  32 each  delivered updates / delivered mispredicts.
REQ-014 SHALL have port ovf  output  1  sticky overflow flag.

Function
REQ-015 SHALL hold a circular FIFO of DEPTH entries {res, correct, g_ind, l_ind}, with head and tail pointers wrapping modulo DEPTH and an occupancy count 0..DEPTH.
REQ-016 SHALL enqueue per cycle, when rdy_in high: c0 if c0_valid; c1 if c1_valid; c0 at tail and c1 at tail+1 when both valid; c1 alone at tail when only c1 valid.
REQ-017 SHALL drive br_req = (count != 0) combinationally, with br_res/br_correct/br_g_ind/br_l_ind from the head entry; outputs are zero when empty.
REQ-018 SHALL dequeue the head on each rising edge with rdy_in high and count != 0; the predictor has no backpressure.
REQ-019 SHALL take effect, for an entry enqueued into an empty queue, at br_req high in the following cycle (latency 1); no same-cycle bypass.
REQ-020 SHALL update count as count + enqueued - dequeued when enqueue and dequeue coincide; a full queue with one dequeue accepts one new entry.
REQ-021 SHALL drive q_full = (DEPTH - count) < 2, computed from the registered count.
REQ-022 SHALL drop, with no pointer change, any commit that finds no free slot after same-cycle dequeue is accounted; c0 takes priority over c1; any drop sets ovf, which stays set until reset.
REQ-023 SHALL increment stat_total on every dequeue, and stat_miss on every dequeue with head correct == 0; both saturate at 32'hFFFFFFFF.
REQ-024 SHALL change no state (pointers, count, entries, counters, ovf) while rdy_in is low; inputs in such cycles are ignored.

Reset
REQ-025 SHALL clear, while rst_in is low, head, tail, count, ovf, stat_total, and stat_miss to 0; br_req = 0, q_full = 0.
REQ-026 SHALL discard all entries queued at the moment rst_in falls, mid-operation included; normal operation resumes on the first rising edge after rst_in returns high.
REQ-027 SHALL leave entry storage contents undefined after reset; entry storage SHALL NOT affect outputs while empty.

Verification
REQ-028 SHALL pass this scenario: reset, then c0_valid=1, res=1, correct=1, g_ind=5, l_ind=9 for 1 cycle -> next cycle br_req=1, br_res=32'h1, br_g_ind=5, br_l_ind=9; following cycle br_req=0, stat_total=1, stat_miss=0.
REQ-029 SHALL pass this scenario: c0 (res=0, correct=0) and c1 (res=1, correct=1) in same cycle -> c0 entry delivered first, c1 entry next cycle; stat_total=2, stat_miss=1.
REQ-030 SHALL pass this scenario: dual commits for 4 cycles with rdy_in low from cycle 2 onward -> count reaches 6 or less (entries only accepted while rdy_in high), q_full asserted when count >= 7, no delivery while rdy_in low.
REQ-031 SHALL pass this scenario: fill to DEPTH=8 with rdy_in high, then force c0 and c1 valid while full -> one entry accepted (one dequeued), c1 dropped, ovf=1 and held.
REQ-032 SHALL pass this scenario: drive 20 single commits through a DEPTH=8 queue -> pointers wrap; 20 updates emerge in order with matching fields.
REQ-033 SHALL pass this scenario: rst_in pulsed low asynchronously between edges with 3 entries queued -> br_req=0 immediately, counters 0, no stale entry delivered afterwards.
